// File: rtl/audio_frame_scheduler_if.sv
// rtl/audio_frame_scheduler_if.sv - control, clock and sample-handshake bundle for the audio frame scheduler
interface audio_frame_scheduler_if #(
  parameter int OVR_W = 16
);
  logic             pll_lock;
  logic             enable;
  logic             clear_stats;
  logic             rx_valid;
  logic             engine_ready;
  logic             codec_en;
  logic             audio_reset;
  logic             mclk;
  logic             bclk;
  logic             lrclk;
  logic             sample_ready;
  logic             overrun;
  logic [OVR_W-1:0] overrun_count;
  logic [1:0]       state;

  modport master (
    output pll_lock, enable, clear_stats, rx_valid, engine_ready,
    input  codec_en, audio_reset, mclk, bclk, lrclk, sample_ready, overrun,
    input  overrun_count, state
  );

  modport slave (
    input  pll_lock, enable, clear_stats, rx_valid, engine_ready,
    output codec_en, audio_reset, mclk, bclk, lrclk, sample_ready, overrun,
    output overrun_count, state
  );
endinterface

// File: rtl/audio_frame_scheduler.sv
// rtl/audio_frame_scheduler.sv - codec bring-up FSM, I2S clock divider and per-frame sample tick scheduler
module audio_frame_scheduler #(
  parameter int MCLK_HALF   = 5,
  parameter int BCLK_HALF   = 2,
  parameter int FRAME_BCLKS = 64,
  parameter int SETTLE      = 1024,
  parameter int OVR_W       = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  audio_frame_scheduler_if.slave  bus
);
  localparam int MW = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
  localparam int BW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int FW = $clog2(FRAME_BCLKS);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_SETTLE    = 2'd1,
    S_RUN       = 2'd2
  } state_t;

  state_t           r_state;
  logic [MW-1:0]    r_mclk_ctr;
  logic [BW-1:0]    r_bclk_ctr;
  logic [FW-1:0]    r_frame_ctr;
  logic [SW-1:0]    r_settle_ctr;
  logic             r_codec_en;
  logic             r_audio_reset;
  logic             r_mclk;
  logic             r_bclk;
  logic             r_rx_seen;
  logic             r_sample_ready;
  logic             r_overrun;
  logic [OVR_W-1:0] r_ovr_count;

  logic w_mtick;
  logic w_event;
  logic w_drop;

  // mtick marks the clk cycle on which mclk toggles
  assign w_mtick = (r_mclk_ctr == MW'(MCLK_HALF - 1));
  // One event per rx_valid high period; lock loss in the same cycle suppresses it
  assign w_event = bus.rx_valid && !r_rx_seen && (r_state == S_RUN) && bus.pll_lock && bus.enable;
  assign w_drop  = w_event && !bus.engine_ready;

  // Bring-up FSM with the mclk/bclk/lrclk dividers; all outputs registered
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_WAIT_LOCK;
      r_mclk_ctr    <= '0;
      r_bclk_ctr    <= '0;
      r_frame_ctr   <= '0;
      r_settle_ctr  <= '0;
      r_codec_en    <= 1'b0;
      r_audio_reset <= 1'b1;
      r_mclk        <= 1'b0;
      r_bclk        <= 1'b0;
    end else if (!bus.pll_lock) begin
      r_state       <= S_WAIT_LOCK;
      r_mclk_ctr    <= '0;
      r_bclk_ctr    <= '0;
      r_frame_ctr   <= '0;
      r_settle_ctr  <= '0;
      r_codec_en    <= 1'b0;
      r_audio_reset <= 1'b1;
      r_mclk        <= 1'b0;
      r_bclk        <= 1'b0;
    end else begin
      if (r_state != S_WAIT_LOCK) begin
        if (w_mtick) begin
          r_mclk_ctr <= '0;
          r_mclk     <= ~r_mclk;
        end else begin
          r_mclk_ctr <= r_mclk_ctr + MW'(1);
        end
      end
      case (r_state)
        S_WAIT_LOCK: begin
          r_state    <= S_SETTLE;
          r_codec_en <= 1'b1;
        end
        S_SETTLE: begin
          if (r_settle_ctr == SW'(SETTLE - 1)) begin
            r_state       <= S_RUN;
            r_audio_reset <= 1'b0;
            r_settle_ctr  <= '0;
            r_bclk_ctr    <= '0;
            r_frame_ctr   <= '0;
            r_bclk        <= 1'b0;
          end else begin
            r_settle_ctr <= r_settle_ctr + SW'(1);
          end
        end
        S_RUN: begin
          if (w_mtick) begin
            if (r_bclk_ctr == BW'(BCLK_HALF - 1)) begin
              r_bclk_ctr <= '0;
              r_bclk     <= ~r_bclk;
              if (r_bclk) begin
                r_frame_ctr <= r_frame_ctr + FW'(1);
              end
            end else begin
              r_bclk_ctr <= r_bclk_ctr + BW'(1);
            end
          end
        end
        default: r_state <= S_WAIT_LOCK;
      endcase
    end
  end

  // Frame event detection, engine tick / overrun pulses and saturating drop counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_seen      <= 1'b0;
      r_sample_ready <= 1'b0;
      r_overrun      <= 1'b0;
      r_ovr_count    <= '0;
    end else begin
      r_rx_seen      <= bus.rx_valid;
      r_sample_ready <= w_event && bus.engine_ready;
      r_overrun      <= w_drop;
      if (bus.clear_stats) begin
        r_ovr_count <= w_drop ? OVR_W'(1) : '0;
      end else if (w_drop && (r_ovr_count != '1)) begin
        r_ovr_count <= r_ovr_count + OVR_W'(1);
      end
    end
  end

  assign bus.codec_en      = r_codec_en;
  assign bus.audio_reset   = r_audio_reset;
  assign bus.mclk          = r_mclk;
  assign bus.bclk          = r_bclk;
  assign bus.lrclk         = r_frame_ctr[FW-1];
  assign bus.sample_ready  = r_sample_ready;
  assign bus.overrun       = r_overrun;
  assign bus.overrun_count = r_ovr_count;
  assign bus.state         = r_state;
endmodule

// File: tb/tb_audio_frame_scheduler.sv
// tb/tb_audio_frame_scheduler.sv - randomized self-checking bench for audio_frame_scheduler
module tb_audio_frame_scheduler;
  localparam int MH = 5;
  localparam int BH = 2;
  localparam int FB = 64;
  localparam int ST = 1024;
  localparam int OW = 4;
  localparam int CNT_MAX = (1 << OW) - 1;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_cnt = 0;

  audio_frame_scheduler_if #(.OVR_W(OW)) bus ();

  audio_frame_scheduler #(
    .MCLK_HALF(MH), .BCLK_HALF(BH), .FRAME_BCLKS(FB), .SETTLE(ST), .OVR_W(OW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Drives one rx_valid frame (hi cycles high, lo cycles low) and records what the DUT emitted
  task automatic frame(input int hi, input int lo, input bit clr,
                       output int n_sr, output int n_ov, output int sr_idx);
    n_sr = 0;
    n_ov = 0;
    sr_idx = -1;
    for (int i = 0; i < hi + lo; i++) begin
      bus.rx_valid    = (i < hi);
      bus.clear_stats = clr && (i == 0);
      @(posedge clk); #1;
      if (bus.sample_ready === 1'b1) begin
        n_sr++;
        if (sr_idx < 0) sr_idx = i;
      end
      if (bus.overrun === 1'b1) n_ov++;
    end
    bus.clear_stats = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.pll_lock = 0; bus.enable = 0; bus.clear_stats = 0; bus.rx_valid = 0; bus.engine_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.state, bus.codec_en, bus.audio_reset, bus.mclk, bus.bclk, bus.lrclk,
         bus.sample_ready, bus.overrun, bus.overrun_count} !== {2'd0, 1'b0, 1'b1, 5'b0, 4'd0}) begin
      n_errors++;
      $display("FAIL reset_state: got state=%0d codec_en=%b audio_reset=%b mclk=%b bclk=%b lrclk=%b sr=%b ov=%b cnt=%0d, want 0 0 1 0 0 0 0 0 0",
               bus.state, bus.codec_en, bus.audio_reset, bus.mclk, bus.bclk, bus.lrclk,
               bus.sample_ready, bus.overrun, bus.overrun_count);
    end
    rst = 1'b0;
  endtask

  // Lock -> SETTLE -> RUN with clock waveforms predicted from elapsed cycles since lock
  task automatic test_bringup(input int run_cycles);
    int mt, tog, falls;
    logic [6:0] exp_v, got_v;
    bus.pll_lock = 1'b0;
    bus.rx_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if ({bus.state, bus.codec_en, bus.audio_reset, bus.mclk} !== {2'd0, 1'b0, 1'b1, 1'b0}) begin
        n_errors++;
        $display("FAIL wait_lock: got state=%0d codec_en=%b audio_reset=%b mclk=%b, want 0 0 1 0",
                 bus.state, bus.codec_en, bus.audio_reset, bus.mclk);
      end
    end
    bus.pll_lock = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < ST + run_cycles; n++) begin
      mt    = (n >= ST) ? (n / MH - ST / MH) : 0;
      tog   = mt / BH;
      falls = tog / 2;
      exp_v = {(n < ST) ? 2'd1 : 2'd2, 1'b1, (n < ST) ? 1'b1 : 1'b0,
               1'((n / MH) % 2), 1'(tog % 2), 1'((falls / (FB / 2)) % 2)};
      got_v = {bus.state, bus.codec_en, bus.audio_reset, bus.mclk, bus.bclk, bus.lrclk};
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL bringup_clocks n=%0d: got {state,codec_en,audio_reset,mclk,bclk,lrclk}=%b, want %b",
                 n, got_v, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single_tick();
    int hi, n_sr, n_ov, idx;
    bus.enable = 1'b1;
    bus.engine_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      hi = (f == 0) ? 3 : int'($urandom_range(1, 5));
      frame(hi, int'($urandom_range(1, 4)), 1'b0, n_sr, n_ov, idx);
      n_checks++;
      if (n_sr !== 1 || idx !== 0 || n_ov !== 0) begin
        n_errors++;
        $display("FAIL single_tick f=%0d hi=%0d: got ticks=%0d at idx=%0d overruns=%0d, want 1 at 0, 0",
                 f, hi, n_sr, idx, n_ov);
      end
    end
  endtask

  task automatic test_overrun();
    int n_sr, n_ov, idx, tot_sr, tot_ov;
    bus.enable = 1'b1;
    bus.engine_ready = 1'b0;
    tot_sr = 0;
    tot_ov = 0;
    for (int f = 0; f < 3; f++) begin
      frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), 1'b0, n_sr, n_ov, idx);
      tot_sr += n_sr;
      tot_ov += n_ov;
    end
    m_cnt = (m_cnt + 3 > CNT_MAX) ? CNT_MAX : m_cnt + 3;
    n_checks++;
    if (tot_ov !== 3 || tot_sr !== 0 || int'(bus.overrun_count) !== m_cnt) begin
      n_errors++;
      $display("FAIL overrun_x3: got overruns=%0d ticks=%0d count=%0d, want 3 0 %0d",
               tot_ov, tot_sr, bus.overrun_count, m_cnt);
    end
  endtask

  task automatic test_disable();
    int n_sr, n_ov, idx;
    bus.enable = 1'b0;
    for (int f = 0; f < 4; f++) begin
      bus.engine_ready = 1'($urandom_range(0, 1));
      frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), 1'b0, n_sr, n_ov, idx);
      n_checks++;
      if (n_sr !== 0 || n_ov !== 0 || int'(bus.overrun_count) !== m_cnt) begin
        n_errors++;
        $display("FAIL disabled f=%0d: got ticks=%0d overruns=%0d count=%0d, want 0 0 %0d",
                 f, n_sr, n_ov, bus.overrun_count, m_cnt);
      end
    end
    bus.enable = 1'b1;
  endtask

  task automatic test_random_frames();
    int n_sr, n_ov, idx, e_sr, e_ov;
    for (int f = 0; f < 12; f++) begin
      bus.enable       = 1'($urandom_range(0, 1));
      bus.engine_ready = 1'($urandom_range(0, 1));
      e_sr = (bus.enable && bus.engine_ready) ? 1 : 0;
      e_ov = (bus.enable && !bus.engine_ready) ? 1 : 0;
      frame(int'($urandom_range(1, 6)), int'($urandom_range(1, 5)), 1'b0, n_sr, n_ov, idx);
      m_cnt = (m_cnt + e_ov > CNT_MAX) ? CNT_MAX : m_cnt + e_ov;
      n_checks++;
      if (n_sr !== e_sr || n_ov !== e_ov || int'(bus.overrun_count) !== m_cnt) begin
        n_errors++;
        $display("FAIL random_frame f=%0d: got ticks=%0d overruns=%0d count=%0d, want %0d %0d %0d",
                 f, n_sr, n_ov, bus.overrun_count, e_sr, e_ov, m_cnt);
      end
    end
  endtask

  task automatic test_saturation_clear();
    int n_sr, n_ov, idx, tot_ov;
    bus.enable = 1'b1;
    bus.engine_ready = 1'b0;
    tot_ov = 0;
    for (int f = 0; f < 20; f++) begin
      frame(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), 1'b0, n_sr, n_ov, idx);
      tot_ov += n_ov;
    end
    m_cnt = (m_cnt + 20 > CNT_MAX) ? CNT_MAX : m_cnt + 20;
    n_checks++;
    if (int'(bus.overrun_count) !== m_cnt || tot_ov !== 20) begin
      n_errors++;
      $display("FAIL saturate: got count=%0d overruns=%0d, want %0d 20", bus.overrun_count, tot_ov, m_cnt);
    end
    frame(2, 2, 1'b1, n_sr, n_ov, idx);
    m_cnt = 1;
    n_checks++;
    if (int'(bus.overrun_count) !== m_cnt || n_ov !== 1) begin
      n_errors++;
      $display("FAIL clear_with_overrun: got count=%0d overruns=%0d, want 1 1", bus.overrun_count, n_ov);
    end
    bus.clear_stats = 1'b1;
    @(posedge clk); #1;
    bus.clear_stats = 1'b0;
    m_cnt = 0;
    n_checks++;
    if (int'(bus.overrun_count) !== m_cnt) begin
      n_errors++;
      $display("FAIL clear_alone: got count=%0d, want 0", bus.overrun_count);
    end
  endtask

  task automatic test_lock_drop();
    int n_sr, n_ov, idx;
    bus.enable = 1'b1;
    bus.engine_ready = 1'b0;
    frame(2, 2, 1'b0, n_sr, n_ov, idx);
    m_cnt = m_cnt + 1;
    bus.engine_ready = 1'b1;
    repeat (int'($urandom_range(5, 60))) @(posedge clk);
    #1;
    bus.pll_lock = 1'b0;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.state, bus.codec_en, bus.audio_reset, bus.mclk, bus.bclk, bus.lrclk, bus.sample_ready, bus.overrun}
        !== {2'd0, 1'b0, 1'b1, 5'b0}) begin
      n_errors++;
      $display("FAIL lock_drop: got state=%0d codec_en=%b audio_reset=%b mclk=%b bclk=%b lrclk=%b sr=%b ov=%b, want 0 0 1 0 0 0 0 0",
               bus.state, bus.codec_en, bus.audio_reset, bus.mclk, bus.bclk, bus.lrclk, bus.sample_ready, bus.overrun);
    end
    n_checks++;
    if (int'(bus.overrun_count) !== m_cnt) begin
      n_errors++;
      $display("FAIL lock_drop_count: got count=%0d, want %0d", bus.overrun_count, m_cnt);
    end
    bus.rx_valid = 1'b0;
    frame(3, 2, 1'b0, n_sr, n_ov, idx);
    n_checks++;
    if (n_sr !== 0 || n_ov !== 0) begin
      n_errors++;
      $display("FAIL event_outside_run: got ticks=%0d overruns=%0d, want 0 0", n_sr, n_ov);
    end
    test_bringup(300);
  endtask

  task automatic test_async_reset();
    int n_sr, n_ov, idx;
    bus.enable = 1'b1;
    bus.engine_ready = 1'b0;
    frame(1, 7, 1'b0, n_sr, n_ov, idx);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.state, bus.codec_en, bus.audio_reset, bus.mclk, bus.bclk, bus.lrclk,
         bus.sample_ready, bus.overrun, bus.overrun_count} !== {2'd0, 1'b0, 1'b1, 5'b0, 4'd0}) begin
      n_errors++;
      $display("FAIL async_reset: got state=%0d codec_en=%b audio_reset=%b mclk=%b bclk=%b lrclk=%b sr=%b ov=%b cnt=%0d, want 0 0 1 0 0 0 0 0 0",
               bus.state, bus.codec_en, bus.audio_reset, bus.mclk, bus.bclk, bus.lrclk,
               bus.sample_ready, bus.overrun, bus.overrun_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_cnt = 0;
  endtask

  initial begin
    test_reset();
    test_bringup(2700);
    test_single_tick();
    test_overrun();
    test_disable();
    test_random_frames();
    test_saturation_clear();
    test_lock_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
